// File: rtl/run_detector.sv
// Moore run detector: flags N consecutive 1s on w, with level and
// non-overlapping pulse modes, a saturating run length and a hit counter.
module run_detector #(
  parameter int N  = 2,
  parameter int CW = 8,
  parameter int RW = $clog2(N + 1)
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          clr,
  input  logic          w,
  input  logic          mode,
  output logic          z,
  output logic [RW-1:0] run,
  output logic [CW-1:0] hits
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HIT
  } state_t;

  localparam logic [RW-1:0] RUN_MAX = RW'(N);

  state_t          state_q, state_d;
  logic [RW-1:0]   run_q, run_d, run_inc;
  logic [CW-1:0]   hits_q, hits_d;
  logic            z_q;
  logic            hit_entry;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    run_inc   = run_q + RW'(1);
    hits_d    = hits_q;
    hit_entry = 1'b0;

    if (clr) begin
      state_d = IDLE;
      run_d   = '0;
      hits_d  = '0;
    end else if (!w) begin
      state_d = IDLE;
      run_d   = '0;
    end else if (state_q != HIT) begin
      run_d = run_inc;
      if (run_inc == RUN_MAX) begin
        state_d   = HIT;
        hit_entry = 1'b1;
      end else begin
        state_d = COUNT;
      end
    end else if (mode) begin
      // Pulse mode restarts a group; with N = 1 that group is already complete.
      run_d = RW'(1);
      if (N == 1) begin
        state_d   = HIT;
        hit_entry = 1'b1;
      end else begin
        state_d = COUNT;
      end
    end

    if (hit_entry && (hits_q != '1)) begin
      hits_d = hits_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      run_q   <= '0;
      hits_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hits_q  <= hits_d;
      z_q     <= (state_d == HIT);
    end
  end

  assign z    = z_q;
  assign run  = run_q;
  assign hits = hits_q;

endmodule

// File: tb/tb_run_detector.sv
// Scoreboard bench for run_detector: four instances share stimulus; the
// stimulus pushes hand-computed expectations that a monitor pops and checks.
module tb_run_detector;

  logic Clock = 1'b0;
  logic Resetn, clr, w, mode;

  logic       z0, z1, z2, z3;
  logic [1:0] run0, run1;
  logic [0:0] run2;
  logic [2:0] run3;
  logic [7:0] hits0, hits1, hits3;
  logic [1:0] hits2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   id;
    logic z;
    int   run;
    int   hits;
  } exp_t;

  exp_t q[$];
  event sample_now;

  always #5 Clock = ~Clock;

  run_detector #(.N(2), .CW(8)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .clr(clr), .w(w), .mode(mode),
    .z(z0), .run(run0), .hits(hits0));
  run_detector #(.N(3), .CW(8)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .clr(clr), .w(w), .mode(mode),
    .z(z1), .run(run1), .hits(hits1));
  run_detector #(.N(1), .CW(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .clr(clr), .w(w), .mode(mode),
    .z(z2), .run(run2), .hits(hits2));
  run_detector #(.N(4), .CW(8)) dut3 (
    .Clock(Clock), .Resetn(Resetn), .clr(clr), .w(w), .mode(mode),
    .z(z3), .run(run3), .hits(hits3));

  task automatic expect_out(input int id, input logic ez, input int er, input int eh);
    exp_t e;
    e.id   = id;
    e.z    = ez;
    e.run  = er;
    e.hits = eh;
    q.push_back(e);
  endtask

  task automatic step(input logic wv, input logic mv, input logic cv);
    @(negedge Clock);
    #1;
    w    = wv;
    mode = mv;
    clr  = cv;
    @(posedge Clock);
    #1;
  endtask

  // Monitor: outputs are only sampled away from the rising edge.
  initial begin
    exp_t e;
    logic az;
    int   ar, ah;
    forever begin
      @(negedge Clock or sample_now);
      while (q.size() > 0) begin
        e  = q.pop_front();
        az = 1'bx;
        ar = -1;
        ah = -1;
        case (e.id)
          0: begin az = z0; ar = int'(run0); ah = int'(hits0); end
          1: begin az = z1; ar = int'(run1); ah = int'(hits1); end
          2: begin az = z2; ar = int'(run2); ah = int'(hits2); end
          3: begin az = z3; ar = int'(run3); ah = int'(hits3); end
          default: ;
        endcase
        tests++;
        if (az !== e.z || ar != e.run || ah != e.hits) begin
          fails++;
          $display("FAIL dut%0d check %0d: got z=%0b run=%0d hits=%0d, expected z=%0b run=%0d hits=%0d",
                   e.id, tests, az, ar, ah, e.z, e.run, e.hits);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    Resetn = 1'b0;
    clr    = 1'b0;
    w      = 1'b0;
    mode   = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) expect_out(i, 1'b0, 0, 0);
    @(negedge Clock);
    #1;
    Resetn = 1'b1;

    // Basic detection, N = 2, level mode
    step(1, 0, 0); expect_out(0, 0, 1, 0);
    step(1, 0, 0); expect_out(0, 1, 2, 1);
    step(1, 0, 0); expect_out(0, 1, 2, 1);
    step(0, 0, 0); expect_out(0, 0, 0, 1);

    // Pulse mode, N = 3, w held high for 9 edges
    step(0, 1, 1); expect_out(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, 0);
      expect_out(1, (i % 3) == 0, ((i - 1) % 3) + 1, i / 3);
    end

    // Broken run, N = 3, level mode
    step(0, 0, 1); expect_out(1, 0, 0, 0);
    step(1, 0, 0); expect_out(1, 0, 1, 0);
    step(1, 0, 0); expect_out(1, 0, 2, 0);
    step(0, 0, 0); expect_out(1, 0, 0, 0);
    step(1, 0, 0); expect_out(1, 0, 1, 0);
    step(1, 0, 0); expect_out(1, 0, 2, 0);
    step(1, 0, 0); expect_out(1, 1, 3, 1);

    // Mode switch out of HIT, then clear beating w = 1, N = 2
    step(0, 0, 1); expect_out(0, 0, 0, 0);
    step(1, 0, 0); expect_out(0, 0, 1, 0);
    step(1, 0, 0); expect_out(0, 1, 2, 1);
    step(1, 1, 0); expect_out(0, 0, 1, 1);
    step(1, 1, 1); expect_out(0, 0, 0, 0);

    // Saturation, N = 1, CW = 2, pulse mode
    step(0, 1, 1); expect_out(2, 0, 0, 0);
    step(1, 1, 0); expect_out(2, 1, 1, 1);
    step(1, 1, 0); expect_out(2, 1, 1, 2);
    step(1, 1, 0); expect_out(2, 1, 1, 3);
    step(1, 1, 0); expect_out(2, 1, 1, 3);
    step(1, 1, 0); expect_out(2, 1, 1, 3);
    step(1, 1, 0); expect_out(2, 1, 1, 3);

    // N = 1 level mode: z follows w one edge later
    step(0, 0, 1); expect_out(2, 0, 0, 0);
    step(1, 0, 0); expect_out(2, 1, 1, 1);
    step(0, 0, 0); expect_out(2, 0, 0, 1);
    step(1, 0, 0); expect_out(2, 1, 1, 2);

    // Asynchronous reset mid-run, N = 4
    step(0, 0, 1); expect_out(3, 0, 0, 0);
    step(1, 0, 0); expect_out(3, 0, 1, 0);
    step(1, 0, 0); expect_out(3, 0, 2, 0);
    step(1, 0, 0); expect_out(3, 0, 3, 0);
    @(negedge Clock);
    #1;
    w      = 1'b0;
    Resetn = 1'b0;
    #1;
    expect_out(3, 0, 0, 0);
    expect_out(2, 0, 0, 0);
    -> sample_now;
    #1;
    Resetn = 1'b1;
    step(1, 0, 0); expect_out(3, 0, 1, 0);
    step(1, 0, 0); expect_out(3, 0, 2, 0);
    step(1, 0, 0); expect_out(3, 0, 3, 0);
    step(1, 0, 0); expect_out(3, 1, 4, 1);

    step(0, 0, 0); expect_out(3, 0, 0, 1);
    repeat (2) @(negedge Clock);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
